// File: rtl/clip_controller.sv
// Record/playback sequencer for two clips sharing one single-port sample memory.
// Latency: writes in the sample_tick cycle; read data reaches spk_sample one cycle after mem_re.
// No back-pressure: sample ticks arrive at least 2 cycles apart and are never stalled.
module clip_controller #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              record,
    input  logic              play,
    input  logic              clipselectionwr,
    input  logic              clipselectionr,
    input  logic              sample_tick,
    input  logic [DATA_W-1:0] mic_sample,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W:0]   mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] spk_sample,
    output logic              spk_valid,
    output logic              recording,
    output logic              playing,
    output logic [1:0]        clip_valid
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RECORD = 2'd1;
    localparam logic [1:0] ST_PLAY   = 2'd2;

    // Length of a completely filled clip, and the last offset inside a clip.
    localparam logic [ADDR_W:0]   LEN_FULL  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] COUNT_MAX = {ADDR_W{1'b1}};

    logic [1:0]        state_q, state_d;
    logic              rec_prev_q, rec_prev_d;
    logic              play_prev_q, play_prev_d;
    logic              cur_clip_q, cur_clip_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W:0]   len_q [2];
    logic [ADDR_W:0]   len_d [2];
    logic              rd_pend_q, rd_pend_d;
    logic [DATA_W-1:0] spk_last_q, spk_last_d;

    logic              rec_cmd;
    logic              play_cmd;
    logic              stop_cmd;
    logic [ADDR_W:0]   count_next_ext;

    assign rec_cmd        = record & ~rec_prev_q;
    assign play_cmd       = play & ~play_prev_q;
    assign stop_cmd       = rec_cmd | play_cmd;
    assign count_next_ext = {1'b0, count_q} + {{ADDR_W{1'b0}}, 1'b1};

    // Address always reflects the active clip/offset; strobes qualify it.
    assign mem_addr   = {cur_clip_q, count_q};
    assign mem_wdata  = mic_sample;
    assign recording  = (state_q == ST_RECORD);
    assign playing    = (state_q == ST_PLAY);
    assign clip_valid = {(len_q[1] != '0), (len_q[0] != '0)};

    // Read data is only valid the cycle after mem_re, so forward it straight
    // through on that cycle and hold a copy for the cycles in between.
    assign spk_valid  = rd_pend_q;
    assign spk_sample = rd_pend_q ? mem_rdata : spk_last_q;

    // Next-state, memory strobes and clip-length bookkeeping.
    always_comb begin
        state_d     = state_q;
        cur_clip_d  = cur_clip_q;
        count_d     = count_q;
        len_d[0]    = len_q[0];
        len_d[1]    = len_q[1];
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        rec_prev_d  = record;
        play_prev_d = play;

        case (state_q)
            ST_IDLE: begin
                // Record wins a tie with play; playing an empty clip is ignored.
                if (rec_cmd) begin
                    state_d    = ST_RECORD;
                    cur_clip_d = clipselectionwr;
                    count_d    = '0;
                end else if (play_cmd && (len_q[clipselectionr] != '0)) begin
                    state_d    = ST_PLAY;
                    cur_clip_d = clipselectionr;
                    count_d    = '0;
                end
            end
            ST_RECORD: begin
                // A stop press beats a coincident tick: that sample is dropped.
                if (stop_cmd) begin
                    len_d[cur_clip_q] = {1'b0, count_q};
                    state_d           = ST_IDLE;
                end else if (sample_tick) begin
                    mem_we  = 1'b1;
                    count_d = count_q + 1'b1;
                    if (count_q == COUNT_MAX) begin
                        len_d[cur_clip_q] = LEN_FULL;
                        state_d           = ST_IDLE;
                    end
                end
            end
            ST_PLAY: begin
                if (stop_cmd) begin
                    state_d = ST_IDLE;
                end else if (sample_tick) begin
                    mem_re  = 1'b1;
                    count_d = count_q + 1'b1;
                    if (count_next_ext == len_q[cur_clip_q]) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Capture the returning sample one cycle after each read strobe.
    always_comb begin
        rd_pend_d  = mem_re;
        spk_last_d = rd_pend_q ? mem_rdata : spk_last_q;
    end

    // State registers; reset discards any partial recording.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            rec_prev_q  <= 1'b0;
            play_prev_q <= 1'b0;
            cur_clip_q  <= 1'b0;
            count_q     <= '0;
            len_q[0]    <= '0;
            len_q[1]    <= '0;
            rd_pend_q   <= 1'b0;
            spk_last_q  <= '0;
        end else begin
            state_q     <= state_d;
            rec_prev_q  <= rec_prev_d;
            play_prev_q <= play_prev_d;
            cur_clip_q  <= cur_clip_d;
            count_q     <= count_d;
            len_q[0]    <= len_d[0];
            len_q[1]    <= len_d[1];
            rd_pend_q   <= rd_pend_d;
            spk_last_q  <= spk_last_d;
        end
    end

endmodule
